binary_search_ctrl: RTL and testbench

- Sequential controller that drives the B operand of the team's 4-bit magnitude comparator and consumes its three flags: gt (A>B), eq (A==B) and lt (A<B).
- A holds a hidden value. The block binary-searches it by issuing one guess per cycle and narrowing the bounds [lo, hi] from the returned flags.
- On eq it reports the found value and the number of comparisons used.
- Placement: directly around the comparator. guess feeds comparator B; comparator outputs feed gt/eq/lt.

---
 rtl/binary_search_ctrl_pkg.sv | 20 ++
 rtl/binary_search_ctrl_if.sv | 28 ++
 rtl/bsearch_bound_update.sv | 40 ++++
 rtl/binary_search_ctrl.sv | 94 +++++++++
 tb/tb_binary_search_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/binary_search_ctrl_pkg.sv
// Shared types and defaults for the binary-search controller that drives
// the B operand of the 4-bit magnitude comparator.
package binary_search_ctrl_pkg;

  localparam int WIDTH_DEF  = 4;
  localparam int STEP_W_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PROBE = 2'd1,
    S_DONE  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  // Exactly one comparator flag must be asserted for a meaningful result.
  function automatic logic flags_onehot(input logic gt, input logic eq, input logic lt);
    return ({gt, eq, lt} == 3'b100) || ({gt, eq, lt} == 3'b010) || ({gt, eq, lt} == 3'b001);
  endfunction

endpackage

// File: rtl/binary_search_ctrl_if.sv
// Bundle between the search controller (master) and the comparator/host side (slave).
interface binary_search_ctrl_if
  import binary_search_ctrl_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int STEP_W = STEP_W_DEF
);
  logic              start;
  logic              gt;
  logic              eq;
  logic              lt;
  logic [WIDTH-1:0]  guess;
  logic              busy;
  logic              done;
  logic              error;
  logic [WIDTH-1:0]  found;
  logic [STEP_W-1:0] steps;

  modport master (
    input  start, gt, eq, lt,
    output guess, busy, done, error, found, steps
  );

  modport slave (
    output start, gt, eq, lt,
    input  guess, busy, done, error, found, steps
  );
endinterface

// File: rtl/bsearch_bound_update.sv
// Combinational narrowing of [lo, hi] from one comparator result, plus the
// midpoint of the new interval. Arithmetic is one bit wider so nothing wraps.
module bsearch_bound_update #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] guess,
  input  logic             gt,
  input  logic             lt,
  output logic [WIDTH-1:0] lo_n,
  output logic [WIDTH-1:0] hi_n,
  output logic [WIDTH-1:0] guess_n,
  output logic             bound_err
);
  logic [WIDTH:0] lo_w;
  logic [WIDTH:0] hi_w;
  logic [WIDTH:0] sum_w;
  logic           unused_sum_lsb;

  always_comb begin
    lo_w      = {1'b0, lo};
    hi_w      = {1'b0, hi};
    bound_err = 1'b0;
    if (gt) begin
      lo_w = {1'b0, guess} + (WIDTH+1)'(1);
      if (guess == {WIDTH{1'b1}}) bound_err = 1'b1;
    end else if (lt) begin
      hi_w = {1'b0, guess} - (WIDTH+1)'(1);
      if (guess == '0) bound_err = 1'b1;
    end
    if (lo_w > hi_w) bound_err = 1'b1;
    sum_w   = lo_w + hi_w;
    lo_n    = lo_w[WIDTH-1:0];
    hi_n    = hi_w[WIDTH-1:0];
    guess_n = sum_w[WIDTH:1];
  end

  assign unused_sum_lsb = sum_w[0];
endmodule

// File: rtl/binary_search_ctrl.sv
// Binary-search controller: one guess per cycle into the comparator, narrowing
// [lo, hi] from gt/eq/lt until eq (DONE) or an inconsistent result (ERR).
module binary_search_ctrl
  import binary_search_ctrl_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  binary_search_ctrl_if.master bus
);
  localparam logic [WIDTH-1:0] MAX_V    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MID_INIT = {1'b0, {(WIDTH-1){1'b1}}};

  state_t            state_r, state_n;
  logic [WIDTH-1:0]  lo_r, hi_r, guess_r, found_r;
  logic [WIDTH-1:0]  lo_nx, hi_nx, guess_nx, found_nx;
  logic [STEP_W-1:0] steps_r, steps_nx;

  logic [WIDTH-1:0]  lo_upd, hi_upd, guess_upd;
  logic              bound_err;

  bsearch_bound_update #(.WIDTH(WIDTH)) u_bound (
    .lo        (lo_r),
    .hi        (hi_r),
    .guess     (guess_r),
    .gt        (bus.gt),
    .lt        (bus.lt),
    .lo_n      (lo_upd),
    .hi_n      (hi_upd),
    .guess_n   (guess_upd),
    .bound_err (bound_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      lo_r    <= '0;
      hi_r    <= MAX_V;
      guess_r <= '0;
      found_r <= '0;
      steps_r <= '0;
    end else begin
      state_r <= state_n;
      lo_r    <= lo_nx;
      hi_r    <= hi_nx;
      guess_r <= guess_nx;
      found_r <= found_nx;
      steps_r <= steps_nx;
    end
  end

  always_comb begin
    state_n  = state_r;
    lo_nx    = lo_r;
    hi_nx    = hi_r;
    guess_nx = guess_r;
    found_nx = found_r;
    steps_nx = steps_r;
    case (state_r)
      S_PROBE: begin
        steps_nx = steps_r + STEP_W'(1);
        // A lone eq cannot violate the bounds, so bound_err only matters for gt/lt.
        if (!flags_onehot(bus.gt, bus.eq, bus.lt) || (!bus.eq && bound_err)) begin
          state_n = S_ERR;
        end else if (bus.eq) begin
          state_n  = S_DONE;
          found_nx = guess_r;
        end else begin
          lo_nx    = lo_upd;
          hi_nx    = hi_upd;
          guess_nx = guess_upd;
        end
      end
      default: begin
        if (bus.start) begin
          state_n  = S_PROBE;
          lo_nx    = '0;
          hi_nx    = MAX_V;
          guess_nx = MID_INIT;
          steps_nx = '0;
        end
      end
    endcase
  end

  assign bus.guess = guess_r;
  assign bus.busy  = (state_r == S_PROBE);
  assign bus.done  = (state_r == S_DONE);
  assign bus.error = (state_r == S_ERR);
  assign bus.found = found_r;
  assign bus.steps = steps_r;
endmodule

// File: tb/tb_binary_search_ctrl.sv
// Bench for binary_search_ctrl: models the comparator around a secret value
// and scoreboards the guess sequence and final found/steps of each search.
module tb_binary_search_ctrl;
  import binary_search_ctrl_pkg::*;

  localparam int W  = 4;
  localparam int SW = 4;

  typedef struct {
    int found;
    int steps;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   secret;
  int   mode;
  int   checks = 0;
  int   errors = 0;
  int   nbusy;
  exp_t sb_q[$];
  int   guess_q[$];

  always #5 clk = ~clk;

  binary_search_ctrl_if #(.WIDTH(W), .STEP_W(SW)) bus ();

  binary_search_ctrl #(.WIDTH(W), .STEP_W(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Comparator model: mode 0 honest, mode 1 gt+eq together, mode 2 gt stuck high.
  assign bus.gt = (mode == 0) ? (secret > int'(bus.guess)) : 1'b1;
  assign bus.eq = (mode == 0) ? (secret == int'(bus.guess)) : (mode == 1);
  assign bus.lt = (mode == 0) ? (secret < int'(bus.guess)) : 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference binary search: expected guess sequence and step count for value a.
  task automatic model(input int a);
    int lo, hi, g, s;
    exp_t e;
    lo = 0;
    hi = (1 << W) - 1;
    s  = 0;
    for (int k = 0; k < 8; k++) begin
      g = (lo + hi) / 2;
      guess_q.push_back(g);
      s++;
      if (g == a) break;
      if (a > g) lo = g + 1;
      else hi = g - 1;
    end
    e.found = a;
    e.steps = s;
    sb_q.push_back(e);
  endtask

  task automatic push_exp(input int f, input int s);
    exp_t e;
    e.found = f;
    e.steps = s;
    sb_q.push_back(e);
  endtask

  // Pulse start, then follow PROBE cycle by cycle comparing each guess.
  task automatic run(input int a, input int pulse_at, output int n_out);
    int n;
    secret    = a;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("done_clr_on_start", bus.done, 0);
    chk("error_clr_on_start", bus.error, 0);
    n = 0;
    while (bus.busy && n < 16) begin
      if (guess_q.size() == 0) chk("extra_guess", bus.guess, 99);
      else chk("guess", bus.guess, guess_q.pop_front());
      bus.start = (n == pulse_at);
      tick();
      bus.start = 1'b0;
      n++;
    end
    if (n >= 16) chk("busy_timeout", bus.busy, 0);
    chk("guesses_left", guess_q.size(), 0);
    guess_q.delete();
    n_out = n;
  endtask

  task automatic check_result(input int n);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sb_q.pop_front();
      chk("done", bus.done, 1);
      chk("busy_after", bus.busy, 0);
      chk("found", bus.found, e.found);
      chk("steps", bus.steps, e.steps);
      chk("busy_cycles", n, e.steps);
    end
  endtask

  initial begin
    rst       = 1'b0;
    mode      = 0;
    secret    = 0;
    bus.start = 1'b0;
    #2 rst = 1'b1;
    #2;
    chk("rst_guess", bus.guess, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_found", bus.found, 0);
    chk("rst_steps", bus.steps, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    tick();
    tick();
    chk("idle_busy", bus.busy, 0);

    // Directed searches
    guess_q = '{7};
    push_exp(7, 1);
    run(7, -1, nbusy);
    check_result(nbusy);

    guess_q = '{7, 11, 13, 14, 15};
    push_exp(15, 5);
    run(15, -1, nbusy);
    check_result(nbusy);

    guess_q = '{7, 3, 1, 0};
    push_exp(0, 4);
    run(0, -1, nbusy);
    check_result(nbusy);

    guess_q = '{7, 11, 9, 10};
    push_exp(10, 4);
    run(10, -1, nbusy);
    check_result(nbusy);

    // Every secret, back-to-back restarts from DONE
    for (int a = 0; a < 16; a++) begin
      model(a);
      run(a, -1, nbusy);
      check_result(nbusy);
      chk("steps_le5", (bus.steps <= 5), 1);
    end

    // gt and eq together on the first probe
    mode    = 1;
    guess_q = '{7};
    run(5, -1, nbusy);
    chk("err2_error", bus.error, 1);
    chk("err2_busy", bus.busy, 0);
    chk("err2_done", bus.done, 0);
    chk("err2_steps", bus.steps, 1);
    chk("err2_found_held", bus.found, 15);
    chk("err2_probes", nbusy, 1);

    // gt stuck high must stop at 15 rather than wrap
    mode    = 2;
    guess_q = '{7, 11, 13, 14, 15};
    run(5, -1, nbusy);
    chk("errgt_error", bus.error, 1);
    chk("errgt_guess", bus.guess, 15);
    chk("errgt_steps", bus.steps, 5);
    chk("errgt_probes", nbusy, 5);
    tick();
    chk("errgt_hold", bus.error, 1);

    // Recovery from ERR
    mode = 0;
    model(3);
    run(3, -1, nbusy);
    check_result(nbusy);

    // Asynchronous reset during the third probe
    secret    = 15;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chk("mid_guess", bus.guess, 13);
    chk("mid_busy", bus.busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_guess", bus.guess, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_found", bus.found, 0);
    chk("arst_steps", bus.steps, 0);
    @(negedge clk) rst = 1'b0;
    tick();
    chk("post_rst_idle", bus.busy, 0);

    // Search after reset with start pulsed mid-PROBE
    guess_q = '{7, 11, 9, 10};
    push_exp(10, 4);
    run(10, 1, nbusy);
    check_result(nbusy);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
